// File: rtl/char_rot_pkg.sv
// Shared widths, character codes and mod-5 position helpers for the character rotator.
package char_rot_pkg;

    localparam int CHAR_W  = 3;
    localparam int NUM_POS = 5;
    localparam int POS_W   = 3;
    localparam int WORD_W  = CHAR_W * NUM_POS;

    typedef logic [POS_W-1:0]  pos_t;
    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CH_H     = 3'd0;
    localparam char_t CH_E     = 3'd1;
    localparam char_t CH_L     = 3'd2;
    localparam char_t CH_O     = 3'd3;
    localparam char_t CH_BLANK = 3'd7;

    localparam pos_t POS_LAST = pos_t'(NUM_POS - 1);

    // Exact wrap at NUM_POS; a plain 3-bit add would visit 5..7.
    function automatic pos_t pos_inc(input pos_t p);
        return (p >= POS_LAST) ? '0 : p + pos_t'(1);
    endfunction

    function automatic pos_t pos_dec(input pos_t p);
        return (p == '0) ? POS_LAST : p - pos_t'(1);
    endfunction

endpackage

// File: rtl/char_rotator_tick_gen.sv
// Prescaler for the rotator: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == CNT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/char_rotator.sv
// Scrolling-word position counter and character rotator for the HEX4..HEX0 display.
// Optional macro CHAR_ROT_STEP_SYNC_EN adds a 2-flop synchronizer on the step input.
module char_rotator
    import char_rot_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    input  logic              dir,
    input  logic              load,
    input  logic [WORD_W-1:0] chars_in,
    output logic [POS_W-1:0]  sel_out,
    output logic [WORD_W-1:0] disp_out,
    output logic              tick_out
);

    logic              auto_tick;
    logic              step_s;
    logic              step_q;
    logic              adv;
    pos_t              pos_q,  pos_d;
    logic [WORD_W-1:0] char_q, char_d;
    logic [WORD_W-1:0] disp_q, disp_d;
    logic              tick_q, tick_d;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enable   (enable),
        .clear    (load),
        .tick     (auto_tick)
    );

`ifdef CHAR_ROT_STEP_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], step};
        end
    end

    assign step_s = sync_q[1];
`else
    assign step_s = step;
`endif

    assign adv = auto_tick | (~enable & step_s & ~step_q);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        char_d = char_q;
        pos_d  = pos_q;
        tick_d = 1'b0;
        if (load) begin
            char_d = chars_in;
            pos_d  = '0;
        end else if (adv) begin
            pos_d  = dir ? pos_dec(pos_q) : pos_inc(pos_q);
            tick_d = 1'b1;
        end
    end

    // Slot k (k=0 is HEX4, top bits) shows character (k + pos) mod NUM_POS.
    always_comb begin
        disp_d = '0;
        for (int k = 0; k < NUM_POS; k++) begin
            int src;
            src = k + int'(pos_d);
            if (src >= NUM_POS) src = src - NUM_POS;
            disp_d[(NUM_POS-1-k)*CHAR_W +: CHAR_W] = char_d[(NUM_POS-1-src)*CHAR_W +: CHAR_W];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            step_q <= 1'b0;
            pos_q  <= '0;
            char_q <= '0;
            disp_q <= '0;
            tick_q <= 1'b0;
        end else begin
            step_q <= step_s;
            pos_q  <= pos_d;
            char_q <= char_d;
            disp_q <= disp_d;
            tick_q <= tick_d;
        end
    end

    assign sel_out  = pos_q;
    assign disp_out = disp_q;
    assign tick_out = tick_q;

endmodule

// File: tb/tb_char_rotator.sv
// Scoreboard bench for char_rotator: a cycle-level reference model predicts each tick, a monitor checks them.
module tb_char_rotator;
    import char_rot_pkg::*;

    localparam int TICK_DIV = 4;
`ifdef CHAR_ROT_STEP_SYNC_EN
    localparam int STEP_LAT = 3;
`else
    localparam int STEP_LAT = 1;
`endif
    localparam int SYNC_D = STEP_LAT - 1;

    logic        clk = 1'b0;
    logic        reset, enable, step, dir, load;
    logic [14:0] chars_in;
    logic [2:0]  sel_out;
    logic [14:0] disp_out;
    logic        tick_out;

    always #5 clk = ~clk;

    char_rotator #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .enable   (enable),
        .step     (step),
        .dir      (dir),
        .load     (load),
        .chars_in (chars_in),
        .sel_out  (sel_out),
        .disp_out (disp_out),
        .tick_out (tick_out)
    );

    typedef struct {
        int          cyc;
        int          pos;
        logic [14:0] disp;
    } exp_t;

    exp_t exp_q[$];

    int   n_checks = 0;
    int   n_pass = 0;
    int   edge_cnt = 0;
    int   tick_count = 0;
    int   last_tick_edge = -1;
    int   reset_edge = 0;
    int   m_pos = 0;
    int   m_presc = 0;
    int   m_ch[5] = '{0, 0, 0, 0, 0};
    logic step_hist[0:32767];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, exp, edge_cnt);
    endtask

    function automatic logic [14:0] model_disp();
        logic [14:0] d;
        d = '0;
        for (int k = 0; k < 5; k++) d[(4-k)*3 +: 3] = 3'(m_ch[(k + m_pos) % 5]);
        return d;
    endfunction

    // Step value seen by the edge detector at edge n: the input from SYNC_D edges earlier, zero near reset.
    function automatic logic eff_step(input int n);
        if (n <= reset_edge + SYNC_D) return 1'b0;
        return step_hist[n - SYNC_D];
    endfunction

    // Reference model, evaluated once per rising edge from the inputs driven before it.
    initial begin : model
        logic fire, rise;
        exp_t e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            step_hist[edge_cnt] = step;
            if (reset) begin
                m_pos = 0;
                m_presc = 0;
                for (int k = 0; k < 5; k++) m_ch[k] = 0;
                reset_edge = edge_cnt;
            end else begin
                fire = enable && (m_presc % TICK_DIV == TICK_DIV - 1);
                if (enable) m_presc++;
                rise = !enable && eff_step(edge_cnt) && !eff_step(edge_cnt - 1);
                if (load) begin
                    for (int k = 0; k < 5; k++) m_ch[k] = int'(chars_in[(4-k)*3 +: 3]);
                    m_pos = 0;
                    m_presc = 0;
                end else if (fire || rise) begin
                    m_pos = dir ? (m_pos + 4) % 5 : (m_pos + 1) % 5;
                    e.cyc  = edge_cnt;
                    e.pos  = m_pos;
                    e.disp = model_disp();
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (tick_out === 1'b1) begin
                tick_count++;
                last_tick_edge = edge_cnt;
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", 32'(tick_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_edge", edge_cnt, e.cyc);
                    check("tick_sel", 32'(sel_out), e.pos);
                    check("tick_disp", 32'(disp_out), 32'(e.disp));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
                void'(exp_q.pop_front());
                check("missing_tick", 32'(tick_out), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0, rise_edge, r_edge;
        bit found;
        reset = 1'b1; enable = 1'b0; step = 1'b0; dir = 1'b0; load = 1'b0; chars_in = '0;
        repeat (3) @(negedge clk);
        check("reset_sel", 32'(sel_out), 32'd0);
        check("reset_disp", 32'(disp_out), 32'd0);
        check("reset_tick", 32'(tick_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        chars_in = {CH_H, CH_E, CH_L, CH_L, CH_O};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_sel", 32'(sel_out), 32'd0);
        check("load_disp", 32'(disp_out), 32'({CH_H, CH_E, CH_L, CH_L, CH_O}));
        check("load_tick", 32'(tick_out), 32'd0);

        enable = 1'b1; dir = 1'b0; t0 = tick_count;
        repeat (4) @(negedge clk);
        check("fwd_first_tick", 32'(tick_out), 32'd1);
        check("fwd_sel1", 32'(sel_out), 32'd1);
        check("fwd_disp1", 32'(disp_out), 32'({CH_E, CH_L, CH_L, CH_O, CH_H}));
        repeat (16) @(negedge clk);
        check("fwd_tick_count", tick_count - t0, 32'd5);
        check("fwd_wrap_sel", 32'(sel_out), 32'd0);

        dir = 1'b1;
        repeat (4) @(negedge clk);
        check("bwd_tick", 32'(tick_out), 32'd1);
        check("bwd_sel", 32'(sel_out), 32'd4);
        check("bwd_disp", 32'(disp_out), 32'({CH_O, CH_H, CH_E, CH_L, CH_L}));

        enable = 1'b0; dir = 1'b0;
        repeat (3) @(negedge clk);
        step = 1'b1;
        rise_edge = edge_cnt + 1;
        t0 = tick_count;
        repeat (10) @(negedge clk);
        check("step_one_tick", tick_count - t0, 32'd1);
        check("step_latency", last_tick_edge - rise_edge + 1, STEP_LAT);
        check("step_sel_wrap", 32'(sel_out), 32'd0);
        step = 1'b0;
        repeat (4) @(negedge clk);

        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_presc % TICK_DIV == TICK_DIV - 1) found = 1'b1;
            else @(negedge clk);
        end
        check("wrap_align", 32'(found), 32'd1);
        chars_in = {CH_O, CH_L, CH_E, CH_H, CH_BLANK};
        load = 1'b1;
        t0 = tick_count;
        @(negedge clk);
        load = 1'b0;
        check("wrap_load_tick", 32'(tick_out), 32'd0);
        check("wrap_load_sel", 32'(sel_out), 32'd0);
        check("wrap_load_disp", 32'(disp_out), 32'({CH_O, CH_L, CH_E, CH_H, CH_BLANK}));
        repeat (3) @(negedge clk);
        check("wrap_no_early_tick", tick_count - t0, 32'd0);
        @(negedge clk);
        check("wrap_next_tick", 32'(tick_out), 32'd1);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (sel_out == 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_sel3", 32'(found), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        r_edge = edge_cnt;
        check("midreset_sel", 32'(sel_out), 32'd0);
        check("midreset_disp", 32'(disp_out), 32'd0);
        check("midreset_tick", 32'(tick_out), 32'd0);
        t0 = tick_count;
        for (int i = 0; i < 12 && tick_count == t0; i++) @(negedge clk);
        check("midreset_first_tick", last_tick_edge - r_edge, TICK_DIV);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            load  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 2) == 0) step = ~step;
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            chars_in = 15'($urandom);
            @(negedge clk);
        end

        reset = 1'b0; load = 1'b0; enable = 1'b0; step = 1'b0;
        repeat (6) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 32'd0);
        check("final_sel", 32'(sel_out), m_pos);
        check("final_disp", 32'(disp_out), 32'(model_disp()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
